ex_mem_skid: RTL

EX_MEM_SKID -- requirements
Module: ex_mem_skid

---
 rtl/ex_mem_skid.sv | 119 +++++++++++
 1 files changed

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: EX->MEM pipeline register with an optional skid slot.
// Define EX_MEM_SKID_BUF_EN to add the skid register and a registered ex_ready_o.
module ex_mem_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic              write_reg_en_i,
  input  logic [ADDR_W-1:0] write_reg_addr_i,
  input  logic [DATA_W-1:0] write_reg_data_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic              mem_write_reg_en_o,
  output logic [ADDR_W-1:0] mem_write_reg_addr_o,
  output logic [DATA_W-1:0] mem_write_reg_data_o,
  output logic [1:0]        count_o
);

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t in_ent;
  ent_t out_q;
  ent_t out_n;
  logic out_v;
  logic out_v_n;
  logic in_xfer;
  logic out_xfer;

  assign in_ent   = '{en:   write_reg_en_i,
                      addr: write_reg_addr_i,
                      data: write_reg_data_i};
  assign in_xfer  = ex_valid_i & ex_ready_o;
  assign out_xfer = out_v & mem_ready_i;

`ifdef EX_MEM_SKID_BUF_EN
  ent_t skid_q;
  ent_t skid_n;
  logic skid_v;
  logic skid_v_n;
  logic rdy_q;

  // While skid is full ex_ready_o is low, so no input can arrive then.
  always_comb begin
    out_n    = out_q;
    out_v_n  = out_v;
    skid_n   = skid_q;
    skid_v_n = skid_v;
    if (flush_i) begin
      out_v_n  = 1'b0;
      skid_v_n = 1'b0;
    end else if (skid_v) begin
      if (out_xfer) begin
        out_n    = skid_q;
        skid_v_n = 1'b0;
      end
    end else if (!out_v || out_xfer) begin
      out_v_n = in_xfer;
      if (in_xfer) out_n = in_ent;
    end else if (in_xfer) begin
      skid_n   = in_ent;
      skid_v_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_q <= '0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
    end else begin
      skid_q <= skid_n;
      skid_v <= skid_v_n;
      rdy_q  <= ~skid_v_n;
    end
  end

  assign ex_ready_o = rdy_q;
  assign count_o    = {1'b0, out_v} + {1'b0, skid_v};
`else
  always_comb begin
    out_n   = out_q;
    out_v_n = out_v;
    if (flush_i) begin
      out_v_n = 1'b0;
    end else if (!out_v || out_xfer) begin
      out_v_n = in_xfer;
      if (in_xfer) out_n = in_ent;
    end
  end

  assign ex_ready_o = ~out_v | mem_ready_i;
  assign count_o    = {1'b0, out_v};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      out_v <= 1'b0;
    end else begin
      out_q <= out_n;
      out_v <= out_v_n;
    end
  end

  // Data fields hold when OUT drains; only the enable is gated.
  assign mem_valid_o          = out_v;
  assign mem_write_reg_en_o   = out_q.en & out_v;
  assign mem_write_reg_addr_o = out_q.addr;
  assign mem_write_reg_data_o = out_q.data;

endmodule
